// File: rtl/systolic_drain_if.sv
// Row-stream handshake bundle between systolic_drain and the writeback path.
// OUT_WIDTH defaults to the narrow width when SYSTOLIC_DRAIN_REQUANT_EN is defined.
interface systolic_drain_if #(
  parameter int ARRAY_SIZE = 4,
`ifdef SYSTOLIC_DRAIN_REQUANT_EN
  parameter int OUT_WIDTH  = 8,
`else
  parameter int OUT_WIDTH  = 32,
`endif
  parameter int ROW_W      = (ARRAY_SIZE > 1) ? $clog2(ARRAY_SIZE) : 1
);
  logic                        out_valid;
  logic                        out_ready;
  logic signed [OUT_WIDTH-1:0] out_data [ARRAY_SIZE];
  logic [ROW_W-1:0]            out_row;
  logic                        out_last;

  modport master (output out_valid, out_data, out_row, out_last, input out_ready);
  modport slave  (input out_valid, out_data, out_row, out_last, output out_ready);
endinterface

// File: rtl/systolic_drain.sv
// Snapshots the MAC array accumulator matrix and streams it out one row per beat.
// Optional requantization to DATA_WIDTH is enabled by defining SYSTOLIC_DRAIN_REQUANT_EN.
module systolic_drain #(
  parameter int ARRAY_SIZE = 4,
  parameter int DATA_WIDTH = 8,
  parameter int ACC_WIDTH  = 32,
  parameter int SHIFT_W    = 5
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic                        start,
  input  logic signed [ACC_WIDTH-1:0] c_in [ARRAY_SIZE][ARRAY_SIZE],
  input  logic [SHIFT_W-1:0]          shift,
  input  logic                        clr_err,
  output logic                        array_clear,
  output logic                        busy,
  output logic                        overrun,
  systolic_drain_if.master            dout
);
`ifdef SYSTOLIC_DRAIN_REQUANT_EN
  localparam int OUT_WIDTH = DATA_WIDTH;
  localparam logic signed [ACC_WIDTH:0] SAT_MAX =
    (ACC_WIDTH+1)'((64'sd1 <<< (DATA_WIDTH - 1)) - 64'sd1);
  localparam logic signed [ACC_WIDTH:0] SAT_MIN = ~SAT_MAX;
  localparam logic signed [ACC_WIDTH:0] RND_ONE = (ACC_WIDTH+1)'(1);

  // Round-half-up, arithmetic shift, then clamp into the signed DATA_WIDTH range.
  function automatic logic signed [DATA_WIDTH-1:0] requant(
    input logic signed [ACC_WIDTH-1:0] v,
    input logic [SHIFT_W-1:0]          sh
  );
    logic signed [ACC_WIDTH:0] ext;
    logic signed [ACC_WIDTH:0] rnd;
    if (sh != '0) rnd = RND_ONE << (sh - SHIFT_W'(1));
    else          rnd = '0;
    ext = $signed({v[ACC_WIDTH-1], v}) + rnd;
    ext = ext >>> sh;
    if (ext > SAT_MAX)      return SAT_MAX[DATA_WIDTH-1:0];
    else if (ext < SAT_MIN) return SAT_MIN[DATA_WIDTH-1:0];
    else                    return ext[DATA_WIDTH-1:0];
  endfunction
`else
  localparam int OUT_WIDTH = ACC_WIDTH;
  localparam int unused_data_width = DATA_WIDTH;
  logic unused_shift_s;
  assign unused_shift_s = ^shift;
`endif
  localparam int ROW_W = (ARRAY_SIZE > 1) ? $clog2(ARRAY_SIZE) : 1;

  typedef enum logic [0:0] {IDLE = 1'b0, STREAM = 1'b1} state_e;

  state_e                      state_q;
  logic signed [OUT_WIDTH-1:0] shadow_q [ARRAY_SIZE][ARRAY_SIZE];
  logic signed [OUT_WIDTH-1:0] shadow_d [ARRAY_SIZE][ARRAY_SIZE];
  logic signed [OUT_WIDTH-1:0] out_data_q [ARRAY_SIZE];
  logic [ROW_W-1:0]            out_row_q;
  logic                        out_valid_q;
  logic                        out_last_q;
  logic                        array_clear_q;
  logic                        overrun_q;

  logic                        xfer_s;
  logic                        last_xfer_s;
  logic                        accept_s;
  logic                        drop_s;
  logic [ROW_W-1:0]            next_row_s;

  // Handshake decode: a start is taken when idle or coincident with the final beat.
  always_comb begin
    xfer_s      = out_valid_q && dout.out_ready;
    last_xfer_s = xfer_s && out_last_q;
    accept_s    = start && ((state_q == IDLE) || last_xfer_s);
    drop_s      = start && (state_q == STREAM) && !last_xfer_s;
    next_row_s  = out_row_q + ROW_W'(1);
  end

  // Capture-time formatting of the incoming matrix.
  always_comb begin
    shadow_d = '{default: '{default: '0}};
    for (int r = 0; r < ARRAY_SIZE; r++) begin
      for (int c = 0; c < ARRAY_SIZE; c++) begin
`ifdef SYSTOLIC_DRAIN_REQUANT_EN
        shadow_d[r][c] = requant(c_in[r][c], shift);
`else
        shadow_d[r][c] = c_in[r][c];
`endif
      end
    end
  end

  // Drain FSM with registered stream outputs; out_data is preloaded with the row to present.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q       <= IDLE;
      shadow_q      <= '{default: '{default: '0}};
      out_data_q    <= '{default: '0};
      out_row_q     <= '0;
      out_valid_q   <= 1'b0;
      out_last_q    <= 1'b0;
      array_clear_q <= 1'b0;
      overrun_q     <= 1'b0;
    end else begin
      array_clear_q <= accept_s;
      if (drop_s)       overrun_q <= 1'b1;
      else if (clr_err) overrun_q <= 1'b0;

      if (accept_s) begin
        shadow_q    <= shadow_d;
        out_data_q  <= shadow_d[0];
        out_row_q   <= '0;
        out_valid_q <= 1'b1;
        out_last_q  <= (ARRAY_SIZE == 1);
        state_q     <= STREAM;
      end else begin
        case (state_q)
          IDLE: begin
            state_q <= IDLE;
          end
          STREAM: begin
            if (last_xfer_s) begin
              out_valid_q <= 1'b0;
              out_last_q  <= 1'b0;
              out_row_q   <= '0;
              state_q     <= IDLE;
            end else if (xfer_s) begin
              out_row_q  <= next_row_s;
              out_data_q <= shadow_q[next_row_s];
              out_last_q <= (next_row_s == ROW_W'(ARRAY_SIZE - 1));
            end
          end
          default: begin
            state_q     <= IDLE;
            out_valid_q <= 1'b0;
            out_last_q  <= 1'b0;
          end
        endcase
      end
    end
  end

  assign dout.out_valid = out_valid_q;
  assign dout.out_data  = out_data_q;
  assign dout.out_row   = out_row_q;
  assign dout.out_last  = out_last_q;
  assign array_clear    = array_clear_q;
  assign overrun        = overrun_q;
  assign busy           = (state_q == STREAM);
endmodule

// File: doc/systolic_drain.md
# systolic_drain

Result-side companion to the systolic MAC array: captures the ARRAY_SIZE x ARRAY_SIZE accumulator matrix on command and streams it out one row per beat over a valid/ready interface. Sits between the array's `c_out` and the downstream writeback/SRAM path. Frees the array for the next tile as soon as the snapshot is taken, and optionally requantizes 32-bit accumulators to DATA_WIDTH.

## Interface
Parameters:
- `ARRAY_SIZE`, 4: array dimension, rows/cols.
- `DATA_WIDTH`, 8: requantized output width.
- `ACC_WIDTH`, 32: accumulator width.
- `SHIFT_W`, 5: width of the requant shift amount.
- Derived `OUT_WIDTH`: DATA_WIDTH with `SYSTOLIC_DRAIN_REQUANT_EN` defined, else ACC_WIDTH.

Ports (one clock; reset is asynchronous and active-high):
- `clk` in 1: clock.
- `reset` in 1: asynchronous, active-high reset.
- `start` in 1: capture request, single-cycle pulse.
- `c_in` in [ARRAY_SIZE][ARRAY_SIZE] x ACC_WIDTH signed: accumulator matrix, `c_in[row][col]`.
- `shift` in SHIFT_W: requant right-shift, sampled at capture. Ignored when the macro is undefined.
- `clr_err` in 1: clears `overrun`.
- `array_clear` out 1: one-cycle pulse on each accepted capture, used to clear the array accumulators.
- `busy` out 1: snapshot held, not fully drained.
- `out_valid` out 1: row beat valid.
- `out_ready` in 1: downstream accepts.
- `out_data` out [ARRAY_SIZE] x OUT_WIDTH signed: row elements, `out_data[col]`.
- `out_row` out clog2(ARRAY_SIZE): index of the current row.
- `out_last` out 1: high with the final row.
- `overrun` out 1: sticky flag, a start was dropped.

## Operation
- FSM states are IDLE and STREAM.
- **IDLE, `start`=1:**
  - Register all of `c_in` into the shadow buffer, after formatting.
  - Pulse `array_clear`.
  - Set `out_row`=0 and go to STREAM.
- **STREAM:**
  - `out_valid`=1. `out_data` = shadow row `out_row`. `out_last` = (`out_row`==ARRAY_SIZE-1).
  - A beat transfers on `out_valid && out_ready`. `out_row` then increments.
  - On a transfer with `out_last`, return to IDLE.
- **Back-to-back:** `start` in the same cycle as the last-row transfer is accepted. The new snapshot is captured and STREAM continues at row 0 with no bubble.
- **Start while busy:** `start` in STREAM, other than on the last-row transfer, is ignored and sets `overrun`. The snapshot is unaffected and there is no `array_clear`.
- **`overrun`:** sticky until `clr_err`. If `clr_err` and a new overrun occur in the same cycle, the set wins.
- **Output stability:** while `out_valid`=1 and `out_ready`=0, `out_data`, `out_row` and `out_last` hold stable. `out_valid` never drops without a transfer.
- **`busy`:** equals (state==STREAM).

## Timing
- **Reset values:** state IDLE; `out_valid`, `busy`, `out_last`, `array_clear`, `overrun` = 0; `out_row`=0; `out_data` all 0; shadow buffer all 0.
- **Reset mid-stream:** aborts the stream immediately. Remaining rows are discarded.
- **Capture latency:** `start` high in cycle T captures `c_in` at the T edge. `array_clear` and `out_valid` are high in T+1, with row 0 presented.
- **Drain time:** minimum ARRAY_SIZE cycles with `out_ready` held high. Row 3 transfers in T+4 for ARRAY_SIZE=4.
- **End of stream:** after the last transfer, `out_valid` and `busy` are 0 in the next cycle, unless a back-to-back start occurred.
- **Input hold:** `c_in` needs to be valid only in cycle T.

## Configuration
- **`SYSTOLIC_DRAIN_REQUANT_EN` defined:** each element is formatted at capture as follows.
  - If `shift`>0, add 2^(`shift`-1), computed in ACC_WIDTH+1 bits.
  - Arithmetic right-shift by `shift`.
  - Saturate to [-2^(DATA_WIDTH-1), 2^(DATA_WIDTH-1)-1].
  - The shadow buffer and `out_data` are DATA_WIDTH wide.
- **Undefined:** elements pass through unmodified at ACC_WIDTH. `shift` is unused and no requant logic is present.

## Test plan
- **Basic drain:** reset, then `c_in[r][c]`=r*4+c, `start` pulse, `out_ready`=1.
  - Rows 0..3 arrive in 4 consecutive cycles, with row 2 = {8,9,10,11}.
  - `out_last` is high only on row 3. `array_clear` is one pulse. `busy` falls after row 3.
- **Backpressure:** `out_ready` toggles 1,0,0,1,...
  - `out_data` and `out_row` hold stable during stalls.
  - Exactly 4 transfers occur and no row is duplicated.
- **Back-to-back:** second `start` with a new matrix (all 7) coincident with the row-3 transfer.
  - Next cycle shows row 0 = {7,7,7,7} and no idle gap. `overrun`=0.
- **Overrun:** `start` during row 1 with `out_ready`=0.
  - `overrun`=1 and the original data is drained intact. `clr_err` then returns `overrun` to 0.
- **Requant (macro on):** `shift`=4 with elements 1000, -1000, 40000 and 7.
  - Outputs are 63, -62, 127 (saturated) and 0.
- **Async reset mid-stream:** assert `reset` after row 1 transfers.
  - All outputs go to reset values immediately. A following `start` drains fresh data from row 0.
